dll_dllp_receiver: RTL and testbench
====================================

// Module: dll_dllp_receiver
// PURPOSE
//  Receive-side counterpart of the DLL DLLP generator. Takes one DLLP per cycle from the PHY deframer.
//  Checks the LCRC16 and decodes Ack/Nak, InitFC1/InitFC2 and UpdateFC for VC0.
//  Drives Ack/Nak sequence events to the retry buffer, FC credit limits to the TL transmit gate,
//  and InitFC progress flags (FI1/FI2) to the DLCMSM. Registered 2-stage pipeline.
// PARAMETERS
//  SEQ_BITS   12   Ack/Nak sequence number width
//  HDR_BITS    8   header credit field width
//  DATA_BITS  12   data credit field width
// PORTS
//  sclk             in   1   clock
//  srst_n           in   1   asynchronous active-low reset
//  dllp_valid_i     in   1   one DLLP present this cycle
//  dllp_i           in  48   {byte0..byte3, crc_hi, crc_lo}; byte0 = dllp_i[47:40]
//  DLCM_state_i     in   2   DL_INACTIVE / DL_INIT / DL_ACTIVE (codes from pkg)
//  ack_valid_o      out  1   1-clk pulse: forward Ack received
//  nak_valid_o      out  1   1-clk pulse: Nak received
//  acknak_seq_o     out SEQ_BITS   seq carried by the Ack/Nak, valid with either pulse
//  fc_limit_ph_o    out HDR_BITS   posted header credit limit (same form for NP, CPL)
//  fc_limit_pd_o    out DATA_BITS  posted data credit limit (same form for NP, CPL)
//  fi1_o            out  1   InitFC1 received for P, NP and Cpl (level)
//  fi2_o            out  1   InitFC2/UpdateFC received after FI1 (level)
//  crc_err_o        out  1   1-clk pulse: LCRC16 mismatch, DLLP dropped
// BEHAVIOUR
//  Reset: all outputs 0, all limits 0, last_acked_seq = all-ones (4095).
//  Pipeline stages:
//   - S0 registers dllp_i.
//   - S1 computes CRC16 (poly 0x100B, init 0xFFFF, over bytes 0-3, inverted, compared with crc field).
//   - S2 registers decode results. Outputs change 2 cycles after dllp_valid_i; back-to-back accepted.
//  Type decode (byte0):
//   - Ack 0x00, Nak 0x10: seq = {byte2[3:0], byte3}.
//   - InitFC1 0x4x/0x5x/0x6x, InitFC2 0xCx/0xDx/0xEx, UpdateFC 0x8x/0x9x/0xAx = P/NP/Cpl; x = VC id.
//   - FC fields: Hdr = {byte1[5:0], byte2[7:6]}; Data = {byte2[3:0], byte3}.
//   - VC id != 0 or undefined type: silently dropped, no outputs.
//  State gating:
//   - DL_INACTIVE: everything dropped; fi1/fi2 and all limits cleared next cycle.
//   - DL_INIT: only InitFC1/InitFC2/UpdateFC processed.
//   - DL_ACTIVE: all types processed.
//  FC state machine: FC_IDLE -> FC_INIT1 -> FC_INIT2.
//   - IDLE: per-type InitFC1 flags accumulate; each first InitFC1 loads that type's limits.
//   - IDLE -> INIT1: all three flags set; fi1_o asserts.
//   - INIT1 -> INIT2: any InitFC2 or UpdateFC; fi2_o asserts.
//   - Repeated InitFC1/InitFC2 after loading: ignored, limits unchanged.
//   - UpdateFC loads limits only in INIT2. A value of 0 at init (infinite credits) stays 0; later UpdateFC
//     for that type is ignored.
//   - DLCM -> DL_INACTIVE from any state: back to IDLE.
//  Ack handling:
//   - d = (seq - last_acked_seq) mod 2^SEQ_BITS.
//   - d == 0: duplicate, dropped.
//   - 1 <= d < 2^(SEQ_BITS-1): forward; pulse, update last_acked_seq.
//   - Otherwise: stale, dropped.
//   - Wrap 4095 -> 0 is forward (d = 1).
//  Nak handling: always pulses, last_acked_seq = seq.
//  Bad CRC: crc_err_o pulses, no other output or state changes. CRC check precedes all gating.
//  Reset mid-pipeline: in-flight DLLPs discarded, no pulse emitted.
// STRUCTURE
//  dll_pkg:
//   - DLLP type codes
//   - DLCM state enum
//   - dllp_t struct (type, byte1..3, crc)
//   - function crc16_dllp(logic [31:0])
//   - fc_state_e enum
//  Sub-module dll_dllp_crc16_check: combinational S1 checker using pkg function. Rest is a flat module.
// TESTING
//  1. DL_INIT; InitFC1-P/NP/Cpl (Hdr 0x20, Data 0x080) -> fi1_o=1 after 3rd +2clk; all limits loaded.
//  2. Then UpdateFC-P Hdr 0x25 -> fi2_o=1; ph=0x25. Repeat InitFC1-P Hdr 0x10 -> ph stays 0x25.
//  3. DL_ACTIVE; Ack seq 5 then Ack seq 5 -> one ack_valid_o pulse, acknak_seq_o=5.
//  4. Ack 4094, 4095, 0 -> three pulses. Then Ack 2100 (d >= 2048) -> none.
//  5. Flip crc bit on Ack 7 -> crc_err_o pulse, no ack. Nak seq 3 -> nak pulse, acknak_seq_o=3.
//  6. srst_n low mid-burst / DLCM -> DL_INACTIVE -> no pulses; fi1/fi2 and limits 0.

Source files
------------

// File: rtl/dll_pkg.sv
// Shared types and helpers for the DLL DLLP receive path: type codes,
// DLCM and flow-control state encodings, DLLP layout and the LCRC16 routine.
package dll_pkg;

    localparam logic [7:0]  DLLP_ACK      = 8'h00;
    localparam logic [7:0]  DLLP_NAK      = 8'h10;

    // Flow-control DLLPs carry their class in byte0[7:6] and P/NP/Cpl in byte0[5:4].
    localparam logic [1:0]  FC_CLS_INIT1  = 2'b01;
    localparam logic [1:0]  FC_CLS_UPDATE = 2'b10;
    localparam logic [1:0]  FC_CLS_INIT2  = 2'b11;

    localparam logic [15:0] CRC16_POLY    = 16'h100B;

    typedef enum logic [1:0] {
        DL_INACTIVE = 2'b00,
        DL_INIT     = 2'b01,
        DL_ACTIVE   = 2'b10
    } dlcm_state_e;

    typedef enum logic [1:0] {
        FC_IDLE  = 2'b00,
        FC_INIT1 = 2'b01,
        FC_INIT2 = 2'b10
    } fc_state_e;

    typedef struct packed {
        logic [7:0]  dtype;
        logic [7:0]  byte1;
        logic [7:0]  byte2;
        logic [7:0]  byte3;
        logic [15:0] crc;
    } dllp_t;

    function automatic logic [15:0] crc16_dllp(input logic [31:0] data);
        logic [15:0] crc;
        logic        fb;
        crc = 16'hFFFF;
        for (int i = 31; i >= 0; i--) begin
            fb  = crc[15] ^ data[i];
            crc = {crc[14:0], 1'b0};
            if (fb) begin
                crc = crc ^ CRC16_POLY;
            end
        end
        return ~crc;
    endfunction

endpackage

// File: rtl/dll_dllp_crc16_check.sv
// Combinational LCRC16 check of a registered DLLP: high when the carried
// CRC matches the one recomputed over bytes 0-3.
module dll_dllp_crc16_check
    import dll_pkg::*;
(
    input  dllp_t dllp_i,
    output logic  crc_ok_o
);

    always_comb begin
        crc_ok_o = (crc16_dllp({dllp_i.dtype, dllp_i.byte1, dllp_i.byte2, dllp_i.byte3}) == dllp_i.crc);
    end

endmodule

// File: rtl/dll_dllp_receiver.sv
// DLLP receiver: registers each incoming DLLP, checks LCRC16, and decodes
// Ack/Nak sequence events and VC0 flow-control credit limits.
module dll_dllp_receiver
    import dll_pkg::*;
#(
    parameter int SEQ_BITS  = 12,
    parameter int HDR_BITS  = 8,
    parameter int DATA_BITS = 12
) (
    input  logic                 sclk,
    input  logic                 srst_n,
    input  logic                 dllp_valid_i,
    input  logic [47:0]          dllp_i,
    input  logic [1:0]           DLCM_state_i,
    output logic                 ack_valid_o,
    output logic                 nak_valid_o,
    output logic [SEQ_BITS-1:0]  acknak_seq_o,
    output logic [HDR_BITS-1:0]  fc_limit_ph_o,
    output logic [DATA_BITS-1:0] fc_limit_pd_o,
    output logic [HDR_BITS-1:0]  fc_limit_nph_o,
    output logic [DATA_BITS-1:0] fc_limit_npd_o,
    output logic [HDR_BITS-1:0]  fc_limit_cplh_o,
    output logic [DATA_BITS-1:0] fc_limit_cpld_o,
    output logic                 fi1_o,
    output logic                 fi2_o,
    output logic                 crc_err_o
);

    logic                           s0_valid_q, s0_valid_d;
    dllp_t                          s0_dllp_q, s0_dllp_d;
    dlcm_state_e                    s0_dlcm_q, s0_dlcm_d;

    logic                           crc_ok;
    logic [SEQ_BITS-1:0]            rx_seq, seq_dist;
    logic [HDR_BITS-1:0]            rx_hdr;
    logic [DATA_BITS-1:0]           rx_data;
    logic [1:0]                     fc_cls, fc_idx;
    logic                           accept, ack_path, fc_path;
    logic                           is_init1, is_init2, is_update, load_update;

    fc_state_e                      fc_state_q, fc_state_d;
    logic [2:0]                     init1_seen_q, init1_seen_d;
    logic [2:0]                     hdr_inf_q, hdr_inf_d;
    logic [2:0]                     data_inf_q, data_inf_d;
    logic [2:0][HDR_BITS-1:0]       hdr_lim_q, hdr_lim_d;
    logic [2:0][DATA_BITS-1:0]      data_lim_q, data_lim_d;
    logic                           fi1_q, fi1_d, fi2_q, fi2_d;

    logic [SEQ_BITS-1:0]            last_acked_q, last_acked_d;
    logic [SEQ_BITS-1:0]            acknak_seq_q, acknak_seq_d;
    logic                           ack_q, ack_d, nak_q, nak_d, crc_err_q, crc_err_d;

    dll_dllp_crc16_check u_crc_check (
        .dllp_i   (s0_dllp_q),
        .crc_ok_o (crc_ok)
    );

    always_comb begin
        s0_valid_d = dllp_valid_i;
        s0_dllp_d  = dllp_t'(dllp_i);
        s0_dlcm_d  = dlcm_state_e'(DLCM_state_i);
    end

    // The DLCM state captured alongside each DLLP decides which types it may affect.
    always_comb begin
        rx_seq    = SEQ_BITS'({s0_dllp_q.byte2[3:0], s0_dllp_q.byte3});
        rx_hdr    = HDR_BITS'({s0_dllp_q.byte1[5:0], s0_dllp_q.byte2[7:6]});
        rx_data   = DATA_BITS'({s0_dllp_q.byte2[3:0], s0_dllp_q.byte3});
        fc_cls    = s0_dllp_q.dtype[7:6];
        fc_idx    = s0_dllp_q.dtype[5:4];
        accept    = s0_valid_q && crc_ok;
        ack_path  = accept && (s0_dlcm_q == DL_ACTIVE);
        fc_path   = accept && ((s0_dlcm_q == DL_INIT) || (s0_dlcm_q == DL_ACTIVE))
                    && (s0_dllp_q.dtype[3:0] == 4'h0) && (fc_idx != 2'b11);
        is_init1  = fc_path && (fc_cls == FC_CLS_INIT1);
        is_init2  = fc_path && (fc_cls == FC_CLS_INIT2);
        is_update = fc_path && (fc_cls == FC_CLS_UPDATE);
        seq_dist  = rx_seq - last_acked_q;
    end

    // Forward Acks lie in the half-window ahead of the last acknowledged sequence.
    always_comb begin
        ack_d        = 1'b0;
        nak_d        = 1'b0;
        crc_err_d    = s0_valid_q && !crc_ok;
        acknak_seq_d = acknak_seq_q;
        last_acked_d = last_acked_q;
        if (ack_path && (s0_dllp_q.dtype == DLLP_ACK) && (seq_dist != '0) && !seq_dist[SEQ_BITS-1]) begin
            ack_d        = 1'b1;
            acknak_seq_d = rx_seq;
            last_acked_d = rx_seq;
        end else if (ack_path && (s0_dllp_q.dtype == DLLP_NAK)) begin
            nak_d        = 1'b1;
            acknak_seq_d = rx_seq;
            last_acked_d = rx_seq;
        end
    end

    always_comb begin
        fc_state_d   = fc_state_q;
        init1_seen_d = init1_seen_q;
        hdr_inf_d    = hdr_inf_q;
        data_inf_d   = data_inf_q;
        hdr_lim_d    = hdr_lim_q;
        data_lim_d   = data_lim_q;
        fi1_d        = fi1_q;
        fi2_d        = fi2_q;
        load_update  = 1'b0;
        case (fc_state_q)
            FC_IDLE: begin
                if (is_init1 && !init1_seen_q[fc_idx]) begin
                    init1_seen_d[fc_idx] = 1'b1;
                    hdr_lim_d[fc_idx]    = rx_hdr;
                    data_lim_d[fc_idx]   = rx_data;
                    hdr_inf_d[fc_idx]    = (rx_hdr == '0);
                    data_inf_d[fc_idx]   = (rx_data == '0);
                    if (&init1_seen_d) begin
                        fc_state_d = FC_INIT1;
                        fi1_d      = 1'b1;
                    end
                end
            end
            FC_INIT1: begin
                if (is_init2 || is_update) begin
                    fc_state_d  = FC_INIT2;
                    fi2_d       = 1'b1;
                    load_update = is_update;
                end
            end
            default: begin
                load_update = is_update;
            end
        endcase
        // A field advertised as zero at init means infinite credit and is never overwritten.
        if (load_update) begin
            if (!hdr_inf_q[fc_idx]) begin
                hdr_lim_d[fc_idx] = rx_hdr;
            end
            if (!data_inf_q[fc_idx]) begin
                data_lim_d[fc_idx] = rx_data;
            end
        end
        if (s0_dlcm_d == DL_INACTIVE) begin
            fc_state_d   = FC_IDLE;
            init1_seen_d = '0;
            hdr_inf_d    = '0;
            data_inf_d   = '0;
            hdr_lim_d    = '0;
            data_lim_d   = '0;
            fi1_d        = 1'b0;
            fi2_d        = 1'b0;
        end
    end

    always_ff @(posedge sclk or negedge srst_n) begin
        if (!srst_n) begin
            s0_valid_q   <= 1'b0;
            s0_dllp_q    <= '0;
            s0_dlcm_q    <= DL_INACTIVE;
            fc_state_q   <= FC_IDLE;
            init1_seen_q <= '0;
            hdr_inf_q    <= '0;
            data_inf_q   <= '0;
            hdr_lim_q    <= '0;
            data_lim_q   <= '0;
            fi1_q        <= 1'b0;
            fi2_q        <= 1'b0;
            last_acked_q <= '1;
            acknak_seq_q <= '0;
            ack_q        <= 1'b0;
            nak_q        <= 1'b0;
            crc_err_q    <= 1'b0;
        end else begin
            s0_valid_q   <= s0_valid_d;
            s0_dllp_q    <= s0_dllp_d;
            s0_dlcm_q    <= s0_dlcm_d;
            fc_state_q   <= fc_state_d;
            init1_seen_q <= init1_seen_d;
            hdr_inf_q    <= hdr_inf_d;
            data_inf_q   <= data_inf_d;
            hdr_lim_q    <= hdr_lim_d;
            data_lim_q   <= data_lim_d;
            fi1_q        <= fi1_d;
            fi2_q        <= fi2_d;
            last_acked_q <= last_acked_d;
            acknak_seq_q <= acknak_seq_d;
            ack_q        <= ack_d;
            nak_q        <= nak_d;
            crc_err_q    <= crc_err_d;
        end
    end

    assign ack_valid_o     = ack_q;
    assign nak_valid_o     = nak_q;
    assign crc_err_o       = crc_err_q;
    assign acknak_seq_o    = acknak_seq_q;
    assign fi1_o           = fi1_q;
    assign fi2_o           = fi2_q;
    assign fc_limit_ph_o   = hdr_lim_q[0];
    assign fc_limit_pd_o   = data_lim_q[0];
    assign fc_limit_nph_o  = hdr_lim_q[1];
    assign fc_limit_npd_o  = data_lim_q[1];
    assign fc_limit_cplh_o = hdr_lim_q[2];
    assign fc_limit_cpld_o = data_lim_q[2];

endmodule

// File: tb/tb_dll_dllp_receiver.sv
// Bench for dll_dllp_receiver: directed and random DLLPs feed a reference model whose
// expected pulses queue up for a monitor; credit levels are compared at quiet points.
module tb_dll_dllp_receiver;
    import dll_pkg::*;

    localparam int K_ACK = 0;
    localparam int K_NAK = 1;
    localparam int K_CRC = 2;

    logic        sclk = 1'b0;
    logic        srst_n;
    logic        dllpValid;
    logic [47:0] dllpData;
    logic [1:0]  dlcmState;
    logic        ackValid, nakValid, fi1, fi2, crcErr;
    logic [11:0] acknakSeq;
    logic [7:0]  ph, nph, cplh;
    logic [11:0] pd, npd, cpld;

    typedef struct {
        int kind;
        int seq;
    } expT;

    expT expQ[$];
    int  assertions = 0;
    int  failures   = 0;

    int  lastAcked;
    int  phase;
    int  hLim[3];
    int  dLim[3];
    bit  hInf[3];
    bit  dInf[3];
    bit  got1[3];

    always #5 sclk = ~sclk;

    dll_dllp_receiver dut (
        .sclk            (sclk),
        .srst_n          (srst_n),
        .dllp_valid_i    (dllpValid),
        .dllp_i          (dllpData),
        .DLCM_state_i    (dlcmState),
        .ack_valid_o     (ackValid),
        .nak_valid_o     (nakValid),
        .acknak_seq_o    (acknakSeq),
        .fc_limit_ph_o   (ph),
        .fc_limit_pd_o   (pd),
        .fc_limit_nph_o  (nph),
        .fc_limit_npd_o  (npd),
        .fc_limit_cplh_o (cplh),
        .fc_limit_cpld_o (cpld),
        .fi1_o           (fi1),
        .fi2_o           (fi2),
        .crc_err_o       (crcErr)
    );

    // LCRC16 as polynomial long division of the init-seeded message, then inverted.
    function automatic logic [15:0] refCrc(input logic [31:0] data);
        logic [47:0] work;
        work = {data ^ 32'hFFFF_0000, 16'h0000};
        for (int i = 47; i >= 16; i--) begin
            if (work[i]) begin
                work = work ^ (48'h1100B << (i - 16));
            end
        end
        return ~work[15:0];
    endfunction

    task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertions++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic clearFc();
        phase = 0;
        for (int i = 0; i < 3; i++) begin
            hLim[i] = 0;
            dLim[i] = 0;
            hInf[i] = 0;
            dInf[i] = 0;
            got1[i] = 0;
        end
    endtask

    task automatic resetModel();
        lastAcked = 4095;
        clearFc();
    endtask

    task automatic modelDllp(input int b0, input int b1, input int b2, input int b3, input bit bad);
        int seq, hdr, data, hi, lo, t, d;
        seq  = ((b2 & 15) << 8) | b3;
        hdr  = ((b1 & 63) << 2) | ((b2 >> 6) & 3);
        data = seq;
        hi   = (b0 >> 4) & 15;
        lo   = b0 & 15;
        if (bad) begin
            expQ.push_back('{K_CRC, 0});
            return;
        end
        if (dlcmState == DL_INACTIVE) return;
        if (b0 == 8'h00) begin
            if (dlcmState == DL_ACTIVE) begin
                d = (seq - lastAcked + 4096) % 4096;
                if (d >= 1 && d < 2048) begin
                    expQ.push_back('{K_ACK, seq});
                    lastAcked = seq;
                end
            end
            return;
        end
        if (b0 == 8'h10) begin
            if (dlcmState == DL_ACTIVE) begin
                expQ.push_back('{K_NAK, seq});
                lastAcked = seq;
            end
            return;
        end
        if (lo != 0) return;
        if (hi >= 4 && hi <= 6) begin
            t = hi - 4;
            if (phase == 0 && !got1[t]) begin
                got1[t] = 1;
                hLim[t] = hdr;
                dLim[t] = data;
                hInf[t] = (hdr == 0);
                dInf[t] = (data == 0);
                if (got1[0] && got1[1] && got1[2]) phase = 1;
            end
        end else if (hi >= 12 && hi <= 14) begin
            if (phase == 1) phase = 2;
        end else if (hi >= 8 && hi <= 10) begin
            t = hi - 8;
            if (phase >= 1) begin
                phase = 2;
                if (!hInf[t]) hLim[t] = hdr;
                if (!dInf[t]) dLim[t] = data;
            end
        end
    endtask

    task automatic applyStimulus(input int b0, input int b1, input int b2, input int b3, input bit bad);
        logic [31:0] payload;
        logic [47:0] frame;
        payload = {b0[7:0], b1[7:0], b2[7:0], b3[7:0]};
        frame   = {payload, refCrc(payload)};
        if (bad) frame = frame ^ (48'd1 << $urandom_range(0, 47));
        @(negedge sclk);
        dllpData  = frame;
        dllpValid = 1'b1;
        modelDllp(b0, b1, b2, b3, bad);
    endtask

    task automatic sendSeq(input int b0, input int seq, input bit bad);
        applyStimulus(b0, $urandom_range(0, 255), ($urandom_range(0, 15) << 4) | ((seq >> 8) & 15), seq & 255, bad);
    endtask

    task automatic sendFc(input int b0, input int hdr, input int data, input bit bad);
        applyStimulus(b0, (hdr >> 2) & 63, ((hdr & 3) << 6) | ($urandom_range(0, 3) << 4) | ((data >> 8) & 15),
                      data & 255, bad);
    endtask

    task automatic idleCycle();
        @(negedge sclk);
        dllpValid = 1'b0;
        dllpData  = 48'({$urandom(), $urandom()});
    endtask

    task automatic changeState(input logic [1:0] s);
        repeat (3) idleCycle();
        dlcmState = s;
        if (s == DL_INACTIVE) clearFc();
        idleCycle();
    endtask

    task automatic checkOutput();
        repeat (3) idleCycle();
        checkValue("fi1", 32'(fi1), 32'(phase >= 1));
        checkValue("fi2", 32'(fi2), 32'(phase == 2));
        checkValue("limit_ph", 32'(ph), 32'(hLim[0]));
        checkValue("limit_pd", 32'(pd), 32'(dLim[0]));
        checkValue("limit_nph", 32'(nph), 32'(hLim[1]));
        checkValue("limit_npd", 32'(npd), 32'(dLim[1]));
        checkValue("limit_cplh", 32'(cplh), 32'(hLim[2]));
        checkValue("limit_cpld", 32'(cpld), 32'(dLim[2]));
        checkValue("pending_pulses", 32'(expQ.size()), 32'd0);
        expQ.delete();
    endtask

    // Monitor: every pulse the DUT presents must match the oldest queued expectation.
    initial begin
        expT e;
        int  kind;
        forever begin
            @(posedge sclk);
            #1;
            if (srst_n === 1'b1 && (ackValid || nakValid || crcErr)) begin
                assertions++;
                kind = ackValid ? K_ACK : (nakValid ? K_NAK : K_CRC);
                if (int'(ackValid) + int'(nakValid) + int'(crcErr) > 1) begin
                    failures++;
                    $display("[TB] FAIL multi_pulse: got ack=%0b nak=%0b crc=%0b, expected one", ackValid, nakValid, crcErr);
                end else if (expQ.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL unexpected_pulse: got kind %0d seq %0d, expected none", kind, acknakSeq);
                end else begin
                    e = expQ.pop_front();
                    if (e.kind != kind || (kind != K_CRC && int'(acknakSeq) != e.seq)) begin
                        failures++;
                        $display("[TB] FAIL pulse: got kind %0d seq %0d, expected kind %0d seq %0d",
                                 kind, acknakSeq, e.kind, e.seq);
                    end
                end
            end
        end
    end

    initial begin
        int sel, off, t, b0;
        srst_n    = 1'b0;
        dllpValid = 1'b0;
        dllpData  = '0;
        dlcmState = DL_INACTIVE;
        resetModel();
        repeat (3) @(negedge sclk);
        checkValue("reset_seq", 32'(acknakSeq), 32'd0);
        checkValue("reset_pulses", 32'({ackValid, nakValid, crcErr}), 32'd0);
        srst_n = 1'b1;
        checkOutput();

        $display("[TB] InitFC1 for all three types under DL_INIT");
        changeState(DL_INIT);
        sendFc(8'h40, 8'h20, 12'h080, 0);
        sendFc(8'h50, 8'h20, 12'h080, 0);
        sendFc(8'h60, 8'h20, 12'h080, 0);
        idleCycle();
        checkValue("fi1_early", 32'(fi1), 32'd0);
        idleCycle();
        checkValue("fi1_latency", 32'(fi1), 32'd1);
        checkOutput();

        $display("[TB] UpdateFC moves to FI2, repeated InitFC1 ignored");
        sendFc(8'h80, 8'h25, 12'h090, 0);
        sendFc(8'h40, 8'h10, 12'h011, 0);
        checkOutput();
        checkValue("ph_after_update", 32'(ph), 32'h25);

        $display("[TB] Ack window handling under DL_ACTIVE");
        changeState(DL_ACTIVE);
        sendSeq(8'h00, 5, 0);
        sendSeq(8'h00, 5, 0);
        sendSeq(8'h00, 2000, 0);
        sendSeq(8'h00, 4000, 0);
        sendSeq(8'h00, 4094, 0);
        sendSeq(8'h00, 4095, 0);
        sendSeq(8'h00, 0, 0);
        sendSeq(8'h00, 2100, 0);
        checkOutput();

        $display("[TB] Bad CRC then Nak");
        sendSeq(8'h00, 7, 1);
        sendSeq(8'h10, 3, 0);
        checkOutput();

        $display("[TB] Reset mid-burst");
        sendSeq(8'h10, 100, 0);
        sendSeq(8'h10, 200, 0);
        @(negedge sclk);
        srst_n    = 1'b0;
        dllpValid = 1'b0;
        expQ.delete();
        resetModel();
        #2;
        checkValue("midreset_fi1", 32'(fi1), 32'd0);
        checkValue("midreset_ph", 32'(ph), 32'd0);
        checkValue("midreset_pulses", 32'({ackValid, nakValid, crcErr}), 32'd0);
        @(negedge sclk);
        srst_n = 1'b1;
        checkOutput();

        $display("[TB] Infinite credits then DL_INACTIVE clear");
        changeState(DL_INIT);
        sendFc(8'h40, 8'h00, 12'h100, 0);
        sendFc(8'h50, 8'h12, 12'h000, 0);
        sendFc(8'h60, 8'h34, 12'h056, 0);
        sendFc(8'hC0, 8'h77, 12'h777, 0);
        sendFc(8'h80, 8'h33, 12'h200, 0);
        sendFc(8'h90, 8'h44, 12'h300, 0);
        checkOutput();
        changeState(DL_INACTIVE);
        checkOutput();

        $display("[TB] Random traffic");
        changeState(DL_INIT);
        for (int n = 0; n < 600; n++) begin
            sel = $urandom_range(0, 99);
            if (sel < 3) begin
                t = $urandom_range(0, 5);
                changeState(t == 0 ? DL_INACTIVE : (t < 3 ? DL_INIT : DL_ACTIVE));
            end else begin
                sel = $urandom_range(0, 9);
                if (sel <= 2) begin
                    case ($urandom_range(0, 4))
                        0:       off = 0;
                        1:       off = $urandom_range(1, 8);
                        2:       off = 2047 + $urandom_range(0, 2);
                        3:       off = $urandom_range(0, 4095);
                        default: off = 4096 - $urandom_range(1, 8);
                    endcase
                    sendSeq(8'h00, (lastAcked + off) % 4096, $urandom_range(0, 15) == 0);
                end else if (sel == 3) begin
                    sendSeq(8'h10, $urandom_range(0, 4095), $urandom_range(0, 15) == 0);
                end else if (sel <= 8) begin
                    t  = $urandom_range(0, 2);
                    b0 = (sel <= 5) ? (8'h40 + (t << 4)) : ((sel == 6) ? (8'hC0 + (t << 4)) : (8'h80 + (t << 4)));
                    sendFc(b0, ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 255),
                           ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 4095), $urandom_range(0, 15) == 0);
                end else begin
                    if ($urandom_range(0, 1) == 0) b0 = $urandom_range(0, 255);
                    else b0 = ($urandom_range(4, 14) << 4) | $urandom_range(1, 15);
                    sendFc(b0, $urandom_range(0, 255), $urandom_range(0, 4095), 0);
                end
                repeat ($urandom_range(0, 2)) idleCycle();
            end
            if (n % 50 == 49) checkOutput();
        end
        checkOutput();

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
